// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the regfile's single write port between requester A and requester B.
// Each requester feeds a one-entry buffer. A round-robin grant drains one buffer per cycle.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_valid,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic [CNT_W-1:0]  wr_count
);

    typedef enum logic {GrantA = 1'b0, GrantB = 1'b1} grant_e;

    logic              full_a_q, full_a_d, full_b_q, full_b_d;
    logic [REG_W-1:0]  reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    grant_e            last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_a, grant_b;

    // Grant depends only on registered state, so ready never loops back through valid.
    assign grant_a = full_a_q & (~full_b_q | (last_grant_q == GrantB));
    assign grant_b = full_b_q & (~full_a_q | (last_grant_q == GrantA));

    assign a_ready = ~clr & (~full_a_q | grant_a);
    assign b_ready = ~clr & (~full_b_q | grant_b);

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign wr_count         = cnt_q;

    always_comb begin
        full_a_d     = full_a_q;
        reg_a_d      = reg_a_q;
        data_a_d     = data_a_q;
        full_b_d     = full_b_q;
        reg_b_d      = reg_b_q;
        data_b_d     = data_b_q;
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        wreg_d       = wreg_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;

        if (grant_a) begin
            we_d         = 1'b1;
            wreg_d       = reg_a_q;
            wdata_d      = data_a_q;
            full_a_d     = 1'b0;
            last_grant_d = GrantA;
            cnt_d        = cnt_q + CNT_W'(1);
        end else if (grant_b) begin
            we_d         = 1'b1;
            wreg_d       = reg_b_q;
            wdata_d      = data_b_q;
            full_b_d     = 1'b0;
            last_grant_d = GrantB;
            cnt_d        = cnt_q + CNT_W'(1);
        end

        // Writes to r0 complete the handshake but are dropped here.
        if (a_valid && a_ready && (a_reg != '0)) begin
            full_a_d = 1'b1;
            reg_a_d  = a_reg;
            data_a_d = a_data;
        end
        if (b_valid && b_ready && (b_reg != '0)) begin
            full_b_d = 1'b1;
            reg_b_d  = b_reg;
            data_b_d = b_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            full_a_q     <= 1'b0;
            reg_a_q      <= '0;
            data_a_q     <= '0;
            full_b_q     <= 1'b0;
            reg_b_q      <= '0;
            data_b_q     <= '0;
            last_grant_q <= GrantB;
            we_q         <= 1'b0;
            wreg_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            full_a_q     <= full_a_d;
            reg_a_q      <= reg_a_d;
            data_a_q     <= data_a_d;
            full_b_q     <= full_b_d;
            reg_b_q      <= reg_b_d;
            data_b_q     <= data_b_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wreg_q       <= wreg_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences and a randomized run
// against a queue-based reference model. The counter is narrowed to 4 bits to reach wrap.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_reg = '0, b_reg = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [3:0]  wr_count;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
        .clk              (clk),
        .clr              (clr),
        .a_valid          (a_valid),
        .a_reg            (a_reg),
        .a_data           (a_data),
        .a_ready          (a_ready),
        .b_valid          (b_valid),
        .b_reg            (b_reg),
        .b_data           (b_data),
        .b_ready          (b_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .wr_count         (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        clr = c; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
    endtask

    // Called at a negedge; returns at a later negedge with clr released.
    task automatic do_reset();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        qa[$];
    ent_t        qb[$];
    bit          m_last_b;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int unsigned m_cnt;

    task automatic m_reset();
        qa.delete(); qb.delete();
        m_last_b = 1'b1; m_we = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0;
    endtask

    // 0: nobody pending, 1: A drains, 2: B drains
    function automatic int m_winner();
        if (qa.size() != 0 && qb.size() != 0) return m_last_b ? 1 : 2;
        if (qa.size() != 0) return 1;
        if (qb.size() != 0) return 2;
        return 0;
    endfunction

    task automatic m_check();
        int w = m_winner();
        chk("rnd a_ready", {31'd0, a_ready}, {31'd0, (qa.size() == 0 || w == 1)});
        chk("rnd b_ready", {31'd0, b_ready}, {31'd0, (qb.size() == 0 || w == 2)});
        chk("rnd we", {31'd0, ctrl_writeEnable}, {31'd0, m_we});
        chk("rnd reg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
        chk("rnd data", data_writeReg, m_data);
        chk("rnd count", {28'd0, wr_count}, m_cnt % 16);
    endtask

    task automatic m_step();
        int w = m_winner();
        bit ra = (qa.size() == 0 || w == 1);
        bit rb = (qb.size() == 0 || w == 2);
        ent_t e;
        if (w == 1) begin
            e = qa.pop_front(); m_we = 1'b1; m_reg = e.r; m_data = e.d;
            m_last_b = 1'b0; m_cnt++;
        end else if (w == 2) begin
            e = qb.pop_front(); m_we = 1'b1; m_reg = e.r; m_data = e.d;
            m_last_b = 1'b1; m_cnt++;
        end else begin
            m_we = 1'b0;
        end
        if (a_valid && ra && a_reg != 0) begin e.r = a_reg; e.d = a_data; qa.push_back(e); end
        if (b_valid && rb && b_reg != 0) begin e.r = b_reg; e.d = b_data; qb.push_back(e); end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        c;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        ea;
        logic        eb;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edata;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic c, input logic av, input logic [4:0] ar,
                                input logic [31:0] ad, input logic bv, input logic [4:0] br,
                                input logic [31:0] bd, input logic ea, input logic eb,
                                input logic ewe, input logic [4:0] ereg,
                                input logic [31:0] edata, input logic [3:0] ecnt);
        vec_t v;
        v.c = c; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.ea = ea; v.eb = eb; v.ewe = ewe; v.ereg = ereg; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        // Reset with both valids high, then single A write to r5.
        tbl[0]  = mk(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, 0, 5'd0, 32'h0, 4'd0);
        tbl[1]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'h0, 4'd0);
        tbl[2]  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 32'h0, 4'd0);
        tbl[3]  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 1, 5'd5, 32'hDEADBEEF, 4'd1);
        tbl[4]  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd5, 32'hDEADBEEF, 4'd1);
        // Fresh reset, then tie round-robin starting with A.
        tbl[5]  = mk(1, 1, 5'd3, 32'h0, 1, 5'd4, 32'h0, 0, 0, 0, 5'd0, 32'h0, 4'd0);
        tbl[6]  = mk(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 1, 0, 5'd0, 32'h0, 4'd0);
        tbl[7]  = mk(0, 1, 5'd3, 32'h13, 1, 5'd4, 32'h24, 1, 0, 0, 5'd0, 32'h0, 4'd0);
        tbl[8]  = mk(0, 1, 5'd3, 32'h15, 1, 5'd4, 32'h24, 0, 1, 1, 5'd3, 32'h11, 4'd1);
        tbl[9]  = mk(0, 1, 5'd3, 32'h15, 1, 5'd4, 32'h26, 1, 0, 1, 5'd4, 32'h22, 4'd2);
        tbl[10] = mk(0, 1, 5'd3, 32'h17, 1, 5'd4, 32'h26, 0, 1, 1, 5'd3, 32'h13, 4'd3);
        tbl[11] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0, 1, 5'd4, 32'h24, 4'd4);
        tbl[12] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 1, 5'd3, 32'h15, 4'd5);
        // B writes r0: handshake only, no regfile write.
        tbl[13] = mk(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 1, 1, 1, 5'd4, 32'h26, 4'd6);
        tbl[14] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd4, 32'h26, 4'd6);
        tbl[15] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd4, 32'h26, 4'd6);

        #2;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].c, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
            #1;
            chk($sformatf("tbl%0d a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ea});
            chk($sformatf("tbl%0d b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].eb});
            chk($sformatf("tbl%0d we", i), {31'd0, ctrl_writeEnable}, {31'd0, tbl[i].ewe});
            chk($sformatf("tbl%0d reg", i), {27'd0, ctrl_writeReg}, {27'd0, tbl[i].ereg});
            chk($sformatf("tbl%0d data", i), data_writeReg, tbl[i].edata);
            chk($sformatf("tbl%0d count", i), {28'd0, wr_count}, {28'd0, tbl[i].ecnt});
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming: A alone sends r1..r8 back to back.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(0, 1, 5'(k + 1), 32'hA000_0000 + k, 0, 5'd0, 32'd0);
            else       drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            #1;
            if (k < 8) chk("stream a_ready", {31'd0, a_ready}, 32'd1);
            if (k >= 2) begin
                chk("stream we", {31'd0, ctrl_writeEnable}, 32'd1);
                chk("stream reg", {27'd0, ctrl_writeReg}, k - 1);
                chk("stream data", data_writeReg, 32'hA000_0000 + k - 2);
            end
            step();
        end
        #1;
        chk("stream we idle", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("stream count", {28'd0, wr_count}, 32'd8);

        // Mid-operation reset: both buffers full and a write on the port.
        @(negedge clk);
        do_reset();
        drive(0, 1, 5'd7, 32'h1, 1, 5'd9, 32'h2);
        step();
        drive(0, 1, 5'd8, 32'h3, 0, 5'd0, 32'h0);
        #1;
        chk("midrst we before", {31'd0, ctrl_writeEnable}, 32'd0);
        step();
        drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #1;
        chk("midrst we live", {31'd0, ctrl_writeEnable}, 32'd1);
        clr = 1'b1;
        #1;
        chk("midrst we async", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("midrst a_ready", {31'd0, a_ready}, 32'd0);
        chk("midrst b_ready", {31'd0, b_ready}, 32'd0);
        chk("midrst count", {28'd0, wr_count}, 32'd0);
        #2;
        clr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("midrst no write", {31'd0, ctrl_writeEnable}, 32'd0);
            chk("midrst count hold", {28'd0, wr_count}, 32'd0);
        end

        // Counter wrap: 17 writes into a 4-bit counter.
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 19; k++) begin
            if (k < 17) drive(0, 1, 5'((k % 31) + 1), 32'(k), 0, 5'd0, 32'd0);
            else        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            #1;
            if (k == 17) chk("wrap count 16", {28'd0, wr_count}, 32'd0);
            step();
        end
        #1;
        chk("wrap count 17", {28'd0, wr_count}, 32'd1);

        // Randomized traffic against the reference model.
        @(negedge clk);
        do_reset();
        m_reset();
        for (int k = 0; k < 400; k++) begin
            drive(0, ($urandom_range(0, 9) < 7), 5'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31)),
                  $urandom, ($urandom_range(0, 9) < 7),
                  5'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31)), $urandom);
            #1;
            m_check();
            @(posedge clk);
            m_step();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
